// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, IR field map,
// status bit indices and the fetch FSM state type.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam logic [3:0] AM_IMM = 4'd8;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 20;
  localparam int RS_HI  = 19;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 12;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int ST_C = 3;
  localparam int ST_V = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  localparam logic [31:0] IR_RST = 32'h0000_0000;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } fetch_state_e;

endpackage

// File: rtl/ir_fetch_unit_stat_reg.sv
// 4-bit {C,V,N,Z} status register with write enable.
// Written by the ALU, read by branch logic.
module stat_reg
  import sisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_f,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] stat_d;
  logic [3:0] stat_q;

  // load new flags when enabled, otherwise hold
  always_comb begin
    stat_d = stat_q;
    if (en) stat_d = d;
  end

  // status flop
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign q = stat_q;

endmodule

// File: rtl/ir_fetch_unit.sv
// Instruction fetch: req/ack fetch FSM with timeout,
// instruction register, field decode and status reg.
module ir_fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            ir_load,
  input  logic [PC_W-1:0] pc_in,
  output logic            im_req,
  output logic [PC_W-1:0] im_addr,
  input  logic            im_ack,
  input  logic [31:0]     im_rdata,
  output logic            busy,
  output logic            ir_valid,
  output logic            fetch_err,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] br_addr,
  input  logic [3:0]      stat_in,
  input  logic            stat_en,
  output logic [3:0]      stat
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  fetch_state_e    state_d, state_q;
  logic [31:0]     ir_d, ir_q;
  logic            req_d, req_q;
  logic [PC_W-1:0] addr_d, addr_q;
  logic [CW-1:0]   cnt_d, cnt_q;
  logic            vld_d, vld_q;
  logic            err_d, err_q;

  // next-state: accept a load, wait for ack or give up
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (ir_load) begin
          addr_d  = pc_in;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (im_ack) begin
          ir_d    = im_rdata;
          req_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          ir_d    = IR_RST;
          err_d   = 1'b1;
          req_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // fetch state, IR and handshake flops
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_IDLE;
      ir_q    <= IR_RST;
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign im_req    = req_q;
  assign im_addr   = addr_q;
  assign busy      = (state_q == S_REQ);
  assign ir_valid  = vld_q;
  assign fetch_err = err_q;

  assign opcode = ir_q[OPC_HI:OPC_LO];
  assign mm     = ir_q[MM_HI:MM_LO];
  assign rd     = ir_q[RD_HI:RD_LO];
  assign rs     = ir_q[RS_HI:RS_LO];
  assign rt     = ir_q[RT_HI:RT_LO];
  assign imm    = ir_q[IMM_HI:IMM_LO];

  if (PC_W > 16) begin : g_br_wide
    assign br_addr = {{(PC_W-16){1'b0}}, ir_q[15:0]};
  end else begin : g_br_narrow
    assign br_addr = ir_q[PC_W-1:0];
  end

  stat_reg u_stat (
    .clk   (clk),
    .rst_f (rst_f),
    .en    (stat_en),
    .d     (stat_in),
    .q     (stat)
  );

endmodule
